// File: rtl/cnn_scan_sequencer_if.sv
// Scan-sequencer to convolution-datapath bundle: start/stall requests in,
// MAC/clear/write strobes and tap/pixel coordinates out.
interface cnn_scan_sequencer_if;
  logic       go;
  logic       hold;
  logic       acc_clr;
  logic       mac_en;
  logic [7:0] a_row;
  logic [7:0] a_col;
  logic       pad;
  logic [3:0] f_row;
  logic [3:0] f_col;
  logic       out_wr;
  logic [7:0] out_row;
  logic [7:0] out_col;
  logic       busy;
  logic       done;

  modport master (
    input  go, hold,
    output acc_clr, mac_en, a_row, a_col, pad, f_row, f_col,
           out_wr, out_row, out_col, busy, done
  );

  modport slave (
    output go, hold,
    input  acc_clr, mac_en, a_row, a_col, pad, f_row, f_col,
           out_wr, out_row, out_col, busy, done
  );
endinterface

// File: rtl/cnn_scan_sequencer.sv
// Window-scan controller: walks every output pixel and filter tap of a
// strided, zero-padded convolution and strobes clear/MAC/write to the datapath.
module cnn_scan_sequencer #(
  parameter int A_SIZE = 6,
  parameter int F_SIZE = 3,
  parameter int STRIDE = 1,
  parameter int ZPAD   = 0
) (
  input logic                  clk,
  input logic                  reset,
  cnn_scan_sequencer_if.master bus
);

  localparam int              O_SIZE = (A_SIZE + 2*ZPAD - F_SIZE) / STRIDE + 1;
  localparam logic [7:0]        OLAST  = 8'(O_SIZE - 1);
  localparam logic [3:0]        FLAST  = 4'(F_SIZE - 1);
  localparam logic signed [9:0] ALIM   = 10'(A_SIZE);
  localparam logic [9:0]        ZOFF   = 10'(ZPAD);

  typedef enum logic [2:0] {IDLE, CLR, MAC, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic [7:0]        orow, ocol, orow_nx, ocol_nx;
  logic [3:0]        frow, fcol, frow_nx, fcol_nx;
  logic signed [9:0] r, c;
  logic              stall, oob, in_mac;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      orow  <= '0;
      ocol  <= '0;
      frow  <= '0;
      fcol  <= '0;
    end else begin
      state <= state_nx;
      orow  <= orow_nx;
      ocol  <= ocol_nx;
      frow  <= frow_nx;
      fcol  <= fcol_nx;
    end
  end

  // hold only freezes the active scan states; IDLE and DONE always advance
  assign stall = bus.hold && (state == CLR || state == MAC || state == WRITE);

  always_comb begin
    state_nx = state;
    orow_nx  = orow;
    ocol_nx  = ocol;
    frow_nx  = frow;
    fcol_nx  = fcol;
    if (!stall) begin
      case (state)
        IDLE: begin
          if (bus.go) begin
            state_nx = CLR;
            orow_nx  = '0;
            ocol_nx  = '0;
            frow_nx  = '0;
            fcol_nx  = '0;
          end
        end
        CLR: state_nx = MAC;
        MAC: begin
          if (fcol == FLAST) begin
            fcol_nx = '0;
            if (frow == FLAST) begin
              frow_nx  = '0;
              state_nx = WRITE;
            end else begin
              frow_nx = frow + 4'd1;
            end
          end else begin
            fcol_nx = fcol + 4'd1;
          end
        end
        WRITE: begin
          if (ocol == OLAST) begin
            if (orow == OLAST) begin
              state_nx = DONE;
            end else begin
              ocol_nx  = '0;
              orow_nx  = orow + 8'd1;
              state_nx = CLR;
            end
          end else begin
            ocol_nx  = ocol + 8'd1;
            state_nx = CLR;
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Image coordinate of the current tap, offset back by the padding border
  always_comb begin
    r = $signed(10'(int'(orow) * STRIDE) + {6'd0, frow} - ZOFF);
    c = $signed(10'(int'(ocol) * STRIDE) + {6'd0, fcol} - ZOFF);
    oob = r[9] || (r >= ALIM) || c[9] || (c >= ALIM);
  end

  assign in_mac      = (state == MAC);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.acc_clr = (state == CLR)   && !bus.hold;
  assign bus.mac_en  = in_mac           && !bus.hold;
  assign bus.out_wr  = (state == WRITE) && !bus.hold;
  assign bus.pad     = in_mac && oob;
  assign bus.a_row   = (in_mac && !oob) ? r[7:0] : '0;
  assign bus.a_col   = (in_mac && !oob) ? c[7:0] : '0;
  assign bus.f_row   = frow;
  assign bus.f_col   = fcol;
  assign bus.out_row = orow;
  assign bus.out_col = ocol;

endmodule

// File: tb/tb_cnn_scan_sequencer.sv
// Bench for cnn_scan_sequencer: three parameter sets run side by side, each
// watched by a monitor that rebuilds the expected scan order from loop indices.
module tb_cnn_scan_sequencer;

  localparam int PA [3] = '{6, 6, 7};
  localparam int PF [3] = '{3, 3, 3};
  localparam int PS [3] = '{1, 1, 2};
  localparam int PZ [3] = '{0, 1, 0};

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   runs     [3] = '{0, 0, 0};
  int   last_cyc [3] = '{0, 0, 0};

  cnn_scan_sequencer_if bus [3] ();

  cnn_scan_sequencer #(.A_SIZE(6), .F_SIZE(3), .STRIDE(1), .ZPAD(0))
    u_dut0 (.clk(clk), .reset(rst_n), .bus(bus[0]));
  cnn_scan_sequencer #(.A_SIZE(6), .F_SIZE(3), .STRIDE(1), .ZPAD(1))
    u_dut1 (.clk(clk), .reset(rst_n), .bus(bus[1]));
  cnn_scan_sequencer #(.A_SIZE(7), .F_SIZE(3), .STRIDE(2), .ZPAD(0))
    u_dut2 (.clk(clk), .reset(rst_n), .bus(bus[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic note_run(input int g, input int cyc);
    runs[g]++;
    last_cyc[g] = cyc;
  endtask

  // Reference monitors: tap k of a run belongs to pixel k/F^2, tap k%F^2
  for (genvar g = 0; g < 3; g++) begin : mon
    localparam int A = PA[g];
    localparam int F = PF[g];
    localparam int S = PS[g];
    localparam int Z = PZ[g];
    localparam int O = (A + 2*Z - F) / S + 1;

    int          k = 0, w = 0, nclr = 0, cyc = 0, holds = 0;
    int          p, t, r, c, er, ec;
    logic        ep;
    logic        prev_done = 1'b0, prev_hact = 1'b0, hact;
    logic [40:0] coord, prev_coord;

    initial forever begin
      @(negedge clk);
      coord = {bus[g].pad, bus[g].a_row, bus[g].a_col, bus[g].f_row, bus[g].f_col,
               bus[g].out_row, bus[g].out_col};
      if (!rst_n) begin
        check("rst_out", {bus[g].acc_clr, bus[g].mac_en, bus[g].out_wr, bus[g].busy,
                          bus[g].done, coord}, 0);
        k = 0; w = 0; nclr = 0; cyc = 0; holds = 0;
        prev_done = 1'b0; prev_hact = 1'b0;
      end else begin
        if (bus[g].busy) cyc++;
        if (prev_done) check("idle_after_done", bus[g].busy, 0);
        if (!bus[g].busy)
          check("idle_out", {bus[g].acc_clr, bus[g].mac_en, bus[g].out_wr, bus[g].done,
                             bus[g].pad, bus[g].a_row, bus[g].a_col}, 0);
        if (prev_hact) check("hold_frozen", coord, prev_coord);
        hact = bus[g].busy && !bus[g].done && bus[g].hold;
        if (hact) begin
          holds++;
          check("hold_strobes", {bus[g].acc_clr, bus[g].mac_en, bus[g].out_wr}, 0);
        end
        if (bus[g].acc_clr) begin
          check("clr_pos", k, w * F * F);
          nclr++;
        end
        if (bus[g].mac_en) begin
          p  = k / (F * F);
          t  = k % (F * F);
          r  = (p / O) * S + t / F - Z;
          c  = (p % O) * S + t % F - Z;
          ep = (r < 0) || (r >= A) || (c < 0) || (c >= A);
          er = ep ? 0 : r;
          ec = ep ? 0 : c;
          check("tap", coord, {ep, 8'(er), 8'(ec), 4'(t / F), 4'(t % F),
                               8'(p / O), 8'(p % O)});
          k++;
        end
        if (bus[g].out_wr) begin
          check("wr_pos", {bus[g].out_row, bus[g].out_col}, {8'(w / O), 8'(w % O)});
          check("wr_macs", k, (w + 1) * F * F);
          check("wr_clrs", nclr, w + 1);
          w++;
        end
        if (bus[g].done) begin
          check("done_cyc", cyc, O * O * (F * F + 2) + 1 + holds);
          check("done_writes", w, O * O);
          note_run(g, cyc);
          k = 0; w = 0; nclr = 0; cyc = 0; holds = 0;
        end
        prev_done  = bus[g].done;
        prev_hact  = hact;
        prev_coord = coord;
      end
    end
  end

  task automatic set_go(input logic [2:0] m);
    bus[0].go = m[0];
    bus[1].go = m[1];
    bus[2].go = m[2];
  endtask

  task automatic set_hold(input logic [2:0] m);
    bus[0].hold = m[0];
    bus[1].hold = m[1];
    bus[2].hold = m[2];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_go(input logic [2:0] m);
    set_go(m);
    tick(1);
    set_go(3'b000);
  endtask

  task automatic wait_runs(input string tag, input int t0, input int t1, input int t2,
                           input int limit);
    int n = 0;
    while ((runs[0] < t0 || runs[1] < t1 || runs[2] < t2) && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, n < limit, 1);
  endtask

  int b0, b1, b2, n;

  initial begin
    rst_n = 1'b0;
    set_go(3'b000);
    set_hold(3'b000);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // single run on every parameter set
    pulse_go(3'b111);
    wait_runs("tmo_single", 1, 1, 1, 1000);
    check("single_done0", last_cyc[0], 177);
    check("single_done1", last_cyc[1], 397);
    check("single_done2", last_cyc[2], 100);
    tick(3);

    // 5-cycle hold starting at the 4th MAC of pixel 0
    pulse_go(3'b001);
    tick(4);
    set_hold(3'b001);
    tick(5);
    set_hold(3'b000);
    wait_runs("tmo_hold", 2, 1, 1, 1000);
    check("hold_done0", last_cyc[0], 182);
    tick(3);

    // random back-pressure on all instances
    b0 = runs[0]; b1 = runs[1]; b2 = runs[2];
    pulse_go(3'b111);
    n = 0;
    while ((runs[0] < b0 + 1 || runs[1] < b1 + 1 || runs[2] < b2 + 1) && n < 3000) begin
      set_hold({$urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0});
      tick(1);
      n++;
    end
    set_hold(3'b000);
    check("tmo_random", n < 3000, 1);
    tick(3);

    // reset in cycle 50 abandons the scan; next go restarts from pixel (0,0)
    b0 = runs[0]; b1 = runs[1]; b2 = runs[2];
    pulse_go(3'b111);
    tick(49);
    rst_n = 1'b0;
    #1;
    check("rst_imm", {bus[0].acc_clr, bus[0].mac_en, bus[0].out_wr, bus[0].busy,
                      bus[0].done, bus[0].out_row, bus[0].out_col, bus[0].f_row,
                      bus[0].f_col}, 0);
    tick(1);
    rst_n = 1'b1;
    check("rst_no_run", runs[0], b0);
    tick(2);
    pulse_go(3'b111);
    wait_runs("tmo_restart", b0 + 1, b1 + 1, b2 + 1, 1000);
    check("restart_done0", last_cyc[0], 177);
    tick(3);

    // go held high: back-to-back runs, busy-time go pulses start nothing
    b0 = runs[0];
    set_go(3'b111);
    wait_runs("tmo_b2b", b0 + 3, runs[1], runs[2], 2000);
    set_go(3'b000);
    n = 0;
    while ((bus[0].busy || bus[1].busy || bus[2].busy) && n < 1000) begin
      tick(1);
      n++;
    end
    check("tmo_idle", n < 1000, 1);
    check("b2b_runs0", runs[0], b0 + 3);
    check("b2b_done0", last_cyc[0], 177);
    check("total_runs0", runs[0], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
